ecc_dec: RTL and testbench
==========================

// Module: ecc_dec
// PURPOSE
//  Pipelined SECDED Hamming decoder for words produced by ecc_enc. Accepts n+1-bit codewords,
//  computes syndrome and overall parity, corrects single-bit errors, flags double errors.
//  Sits on the read side of ECC-protected storage. Keeps saturating error counters and a sticky first-error syndrome.
// PARAMETERS
//  K       32  information bits per word
//  P0_LSB  1   1: overall parity bit p0 at q_i[0], cw[j] at q_i[j]; 0: p0 at q_i[n], cw[j] at q_i[j-1]
//  CNT_W   16  width of error counters
//  m       derived: smallest m with 2**m >= m+K+1 (6 for K=32); n = m+K (38)
// PORTS
//  clk               in   1      clock
//  rst_n             in   1      asynchronous active-low reset
//  in_valid_i        in   1      codeword valid
//  in_ready_o        out  1      decoder accepts codeword
//  q_i               in   n+1    codeword, layout per P0_LSB
//  out_valid_o       out  1      decoded word valid
//  out_ready_i       in   1      consumer accepts decoded word
//  d_o               out  K      corrected data
//  err_single_o      out  1      single error detected and corrected (qualifies d_o)
//  err_double_o      out  1      uncorrectable error; d_o is raw extracted data, uncorrected
//  syndrome_o        out  m      syndrome of the output word
//  cnt_clr_i         in   1      synchronous clear of counters and sticky capture
//  single_cnt_o      out  CNT_W  count of single errors delivered
//  double_cnt_o      out  CNT_W  count of uncorrectable errors delivered
//  first_syn_o       out  m      syndrome of first error since reset/clear
//  first_syn_vld_o   out  1      first_syn_o holds a capture
// BEHAVIOUR
//  Codeword layout: data bits at non-power-of-2 positions 1..n ascending (d[0] at cw[3]); p[i] at cw[2**(i-1)].
//  Stage 1 (S1): register syndrome s[i] = XOR of cw[j] for all j in 1..n with bit (i-1) of j set, overall parity e = ^q_i, cw.
//  Stage 2 (S2): classify and correct; outputs registered. Latency: exactly 2 cycles with out_ready_i held high.
//    s==0, e==0: clean. s==0, e==1: p0 flipped -> single, data unchanged.
//    s in 1..n, e==1: flip cw[s] -> single. s>n, e==1: uncorrectable -> double.
//    s!=0, e==0: double. err_single_o and err_double_o never both 1.
//  Handshake: global pipe enable en = !out_valid_o | out_ready_i; in_ready_o = en.
//    Input transfer on in_valid_i & in_ready_o; both stages advance only when en=1; bubbles are not squeezed.
//    Outputs stable while out_valid_o=1 and out_ready_i=0. Throughput 1 word/cycle without backpressure.
//  Counters: increment on output transfer (out_valid_o & out_ready_i) of a flagged word; saturate at 2**CNT_W-1.
//    cnt_clr_i together with an increment: clear wins (counter = 0, sticky cleared).
//  Sticky: on first flagged output transfer with first_syn_vld_o=0, capture syndrome_o, set vld; hold until clear/reset.
//  Reset (async, any time, including mid-pipeline): all valids 0, in-flight words dropped, d_o/syndrome_o/flags 0,
//    counters 0, first_syn_o 0, first_syn_vld_o 0. in_ready_o = 1 out of reset.
// STRUCTURE
//  Package ecc_pkg: function calc_m(K), function syndrome over cw, enum ecc_err_e {ECC_OK, ECC_SINGLE, ECC_DOUBLE},
//    shared with ecc_enc so both ends derive m/n identically.
//  Sub-module ecc_err_cnt: CNT_W saturating counter with inc/clr (clr priority), instantiated twice.
//  ecc_dec top: S1/S2 registers, classification, handshake, sticky capture.
// TESTING (K=32, P0_LSB=1, CNT_W=16 unless stated)
//  q_i=0 (enc of 0), out_ready_i=1 -> 2 cycles later d_o=0, flags 0, syndrome_o=0; 32'hFFFF_FFFF encoded -> clean, d_o=32'hFFFF_FFFF.
//  enc(0) with q_i[3] flipped -> d_o=0, err_single_o=1, syndrome_o=3, single_cnt_o=1, first_syn_o=3, vld=1.
//  enc(0) with q_i[0] flipped -> d_o=0, err_single_o=1, syndrome_o=0; q_i[1]^q_i[2] flipped -> err_double_o=1, syndrome_o=3.
//  Stream 8 words, out_ready_i low cycles 3-5 -> in_ready_o low, outputs held, all 8 delivered in order, none lost/duplicated.
//  CNT_W=2: 5 single-error words -> single_cnt_o=3 (saturated); cnt_clr_i on 6th transfer -> 0, first_syn_vld_o=0.
//  rst_n low with 2 words in flight -> out_valid_o=0 immediately, counters 0; no stale word after release.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers so encoder and decoder derive m/n and the bit layout identically.
package ecc_pkg;

    typedef enum logic [1:0] {ECC_OK, ECC_SINGLE, ECC_DOUBLE} ecc_err_e;

    // Upper bound on codeword length handled by the helper functions.
    localparam int CW_MAX = 256;

    function automatic int calc_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < m + k + 1) m++;
        return m;
    endfunction

    function automatic bit is_pow2(input int j);
        return (j > 0) && ((j & (j - 1)) == 0);
    endfunction

    // Codeword position (1-based) of data bit i: the i-th non-power-of-2 position.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int j = 1; j < CW_MAX; j++) begin
            if (!is_pow2(j) && pos == 0) begin
                if (cnt == i) pos = j;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Syndrome = XOR of the positions of all set bits in cw[1..n].
    function automatic int calc_syndrome(input logic [CW_MAX-1:0] cw, input int n);
        int s;
        s = 0;
        for (int j = 1; j < CW_MAX; j++) begin
            if (j <= n && cw[j]) s = s ^ j;
        end
        return s;
    endfunction

endpackage

// File: rtl/ecc_err_cnt.sv
// Saturating event counter; clear has priority over increment.
module ecc_err_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_dec.sv
// Two-stage SECDED decoder: S1 syndrome/parity, S2 classify+correct; 2-cycle latency.
// One global enable stalls both stages whenever the output is held by the consumer.
module ecc_dec
    import ecc_pkg::*;
#(
    parameter int K      = 32,
    parameter int P0_LSB = 1,
    parameter int CNT_W  = 16,
    localparam int M     = calc_m(K),
    localparam int N     = M + K
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N:0]       q_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [K-1:0]     d_o,
    output logic             err_single_o,
    output logic             err_double_o,
    output logic [M-1:0]     syndrome_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] single_cnt_o,
    output logic [CNT_W-1:0] double_cnt_o,
    output logic [M-1:0]     first_syn_o,
    output logic             first_syn_vld_o
);

    logic         en;
    logic [N:1]   cw_in;
    logic [M-1:0] syn_in;
    logic [K-1:0] dat_in;

    logic         s1_vld;
    logic [K-1:0] s1_dat;
    logic [M-1:0] s1_syn;
    logic         s1_e;

    ecc_err_e     cls;
    logic [K-1:0] d_fix;
    logic         xfer;

    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;
    assign xfer       = out_valid_o && out_ready_i;

    assign cw_in  = (P0_LSB != 0) ? q_i[N:1] : q_i[N-1:0];
    assign syn_in = M'(calc_syndrome(CW_MAX'({cw_in, 1'b0}), N));

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_dat
            localparam int POS = data_pos(gi);
            assign dat_in[gi] = cw_in[POS];
            // Only a data position named by the syndrome is flipped; parity-bit hits leave data alone.
            assign d_fix[gi]  = s1_dat[gi] ^ ((cls == ECC_SINGLE) && (s1_syn == M'(POS)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_syn <= '0;
            s1_e   <= 1'b0;
        end else if (en) begin
            s1_vld <= in_valid_i;
            if (in_valid_i) begin
                s1_dat <= dat_in;
                s1_syn <= syn_in;
                s1_e   <= ^q_i;
            end
        end
    end

    always_comb begin
        cls = ECC_OK;
        if (s1_syn == '0) begin
            cls = s1_e ? ECC_SINGLE : ECC_OK;
        end else if (!s1_e) begin
            cls = ECC_DOUBLE;
        end else if (32'(s1_syn) <= 32'(N)) begin
            cls = ECC_SINGLE;
        end else begin
            cls = ECC_DOUBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o  <= 1'b0;
            d_o          <= '0;
            err_single_o <= 1'b0;
            err_double_o <= 1'b0;
            syndrome_o   <= '0;
        end else if (en) begin
            out_valid_o <= s1_vld;
            if (s1_vld) begin
                d_o          <= d_fix;
                err_single_o <= (cls == ECC_SINGLE);
                err_double_o <= (cls == ECC_DOUBLE);
                syndrome_o   <= s1_syn;
            end
        end
    end

    ecc_err_cnt #(.CNT_W(CNT_W)) u_single_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xfer && err_single_o),
        .clr   (cnt_clr_i),
        .cnt   (single_cnt_o)
    );

    ecc_err_cnt #(.CNT_W(CNT_W)) u_double_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xfer && err_double_o),
        .clr   (cnt_clr_i),
        .cnt   (double_cnt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_syn_o     <= '0;
            first_syn_vld_o <= 1'b0;
        end else if (cnt_clr_i) begin
            first_syn_o     <= '0;
            first_syn_vld_o <= 1'b0;
        end else if (xfer && (err_single_o || err_double_o) && !first_syn_vld_o) begin
            first_syn_o     <= syndrome_o;
            first_syn_vld_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_dec.sv
// Randomized + directed bench for ecc_dec against an error-count based reference model.
module tb_ecc_dec;
    import ecc_pkg::*;

    localparam int K = 32;
    localparam int M = 6;
    localparam int N = 38;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i, cnt_clr_i;
    logic [N:0]    q_i;
    logic [K-1:0]  d_o, d2;
    logic          err_single_o, err_double_o, es2, ed2, iv2, ov2;
    logic [M-1:0]  syndrome_o, first_syn_o, syn2, fs2;
    logic          first_syn_vld_o, fv2;
    logic [15:0]   single_cnt_o, double_cnt_o;
    logic [1:0]    sc2, dc2;

    ecc_dec #(.K(K), .P0_LSB(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .q_i(q_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .d_o(d_o),
        .err_single_o(err_single_o), .err_double_o(err_double_o), .syndrome_o(syndrome_o),
        .cnt_clr_i(cnt_clr_i), .single_cnt_o(single_cnt_o), .double_cnt_o(double_cnt_o),
        .first_syn_o(first_syn_o), .first_syn_vld_o(first_syn_vld_o));

    ecc_dec #(.K(K), .P0_LSB(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(iv2), .q_i(q_i),
        .out_valid_o(ov2), .out_ready_i(out_ready_i), .d_o(d2),
        .err_single_o(es2), .err_double_o(ed2), .syndrome_o(syn2),
        .cnt_clr_i(cnt_clr_i), .single_cnt_o(sc2), .double_cnt_o(dc2),
        .first_syn_o(fs2), .first_syn_vld_o(fv2));

    always #5 clk = ~clk;

    typedef struct {
        logic [K-1:0] d;
        logic         s;
        logic         db;
        logic [M-1:0] syn;
        int           acc_cyc;
    } exp_t;

    exp_t         q_exp[$];
    exp_t         pend;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           m_sc, m_dc, m_sc2, m_dc2, n_deliv, bp_cnt;
    logic [M-1:0] m_fs;
    logic         m_fv, accepted, chk_lat, bp_mode, rnd_mode, stalled;
    logic [K-1:0] held_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data at non-power-of-2 positions, parity bits make XOR of set positions zero.
    function automatic logic [N:0] enc(input logic [K-1:0] d);
        logic [N:0] cw;
        int pos, x;
        cw = '0; pos = 1; x = 0;
        for (int i = 0; i < K; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            cw[pos] = d[i];
            if (d[i]) x = x ^ pos;
            pos++;
        end
        for (int i = 0; i < M; i++) cw[1 << i] = x[i];
        cw[0] = ^cw[N:1];
        return cw;
    endfunction

    function automatic logic [K-1:0] extract(input logic [N:0] q);
        logic [K-1:0] d;
        int pos;
        pos = 1;
        for (int i = 0; i < K; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            d[i] = q[pos];
            pos++;
        end
        return d;
    endfunction

    // Expected result follows only from how many bits were flipped and where.
    task automatic mk(input logic [K-1:0] d, input int p1, input int p2,
                      output logic [N:0] q, output exp_t e);
        q = enc(d);
        e.d = d; e.s = 1'b0; e.db = 1'b0; e.syn = '0; e.acc_cyc = 0;
        if (p1 >= 0) q[p1] = ~q[p1];
        if (p2 >= 0) q[p2] = ~q[p2];
        if (p1 >= 0 && p2 >= 0) begin
            e.db = 1'b1; e.syn = M'(p1 ^ p2); e.d = extract(q);
        end else if (p1 >= 0) begin
            e.s = 1'b1; e.syn = M'(p1);
        end
    endtask

    task automatic zero_model();
        m_sc = 0; m_dc = 0; m_sc2 = 0; m_dc2 = 0; m_fs = '0; m_fv = 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        if (bp_mode) begin
            out_ready_i = !(bp_cnt >= 3 && bp_cnt <= 5);
            bp_cnt++;
        end
        if (rnd_mode) begin
            out_ready_i = ($urandom_range(9) < 7);
            cnt_clr_i   = ($urandom_range(49) == 0);
        end
        #1;
        chk("single_cnt", 64'(single_cnt_o), 64'(m_sc));
        chk("double_cnt", 64'(double_cnt_o), 64'(m_dc));
        chk("single_cnt_w2", 64'(sc2), 64'(m_sc2));
        chk("double_cnt_w2", 64'(dc2), 64'(m_dc2));
        chk("first_syn_vld", 64'(first_syn_vld_o), 64'(m_fv));
        chk("first_syn", 64'(first_syn_o), 64'(m_fs));
        if (stalled) begin
            chk("hold_vld", 64'(out_valid_o), 64'd1);
            chk("hold_d", 64'(d_o), 64'(held_d));
        end
        stalled = out_valid_o && !out_ready_i;
        held_d  = d_o;
        if (stalled) chk("in_ready_stall", 64'(in_ready_o), 64'd0);
        if (out_valid_o && out_ready_i) begin
            if (q_exp.size() == 0) begin
                chk("spurious_out", 64'(out_valid_o), 64'd0);
            end else begin
                e = q_exp.pop_front();
                n_deliv++;
                chk("d_o", 64'(d_o), 64'(e.d));
                chk("err_single", 64'(err_single_o), 64'(e.s));
                chk("err_double", 64'(err_double_o), 64'(e.db));
                chk("syndrome", 64'(syndrome_o), 64'(e.syn));
                if (chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
                if (e.s) begin
                    if (m_sc < 65535) m_sc++;
                    if (m_sc2 < 3) m_sc2++;
                end
                if (e.db) begin
                    if (m_dc < 65535) m_dc++;
                    if (m_dc2 < 3) m_dc2++;
                end
                if ((e.s || e.db) && !m_fv) begin
                    m_fv = 1'b1; m_fs = e.syn;
                end
            end
        end
        if (cnt_clr_i) zero_model();
        if (in_valid_i && in_ready_o) begin
            pend.acc_cyc = cyc;
            q_exp.push_back(pend);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [K-1:0] d, input int p1, input int p2);
        logic [N:0] q;
        mk(d, p1, p2, q, pend);
        q_i = q; in_valid_i = 1'b1; accepted = 1'b0;
        for (int t = 0; t < 60 && !accepted; t++) tick();
        if (!accepted) chk("accept_timeout", 64'(accepted), 64'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q_exp.size() != 0; t++) tick();
        if (q_exp.size() != 0) chk("drain_timeout", 64'(q_exp.size()), 64'd0);
        tick();
    endtask

    initial begin
        int p1, p2, d0;
        in_valid_i = 1'b0; out_ready_i = 1'b1; cnt_clr_i = 1'b0; q_i = '0;
        chk_lat = 1'b0; bp_mode = 1'b0; rnd_mode = 1'b0; stalled = 1'b0; held_d = '0;
        n_deliv = 0; bp_cnt = 0; accepted = 1'b0;
        zero_model();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_d_o", 64'(d_o), 64'd0);
        chk("rst_syndrome", 64'(syndrome_o), 64'd0);
        chk("rst_flags", 64'({err_single_o, err_double_o}), 64'd0);
        chk("rst_first_vld", 64'(first_syn_vld_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed words, latency checked with ready held high.
        chk_lat = 1'b1;
        send(32'h0, -1, -1);          drain();
        send(32'hFFFF_FFFF, -1, -1);  drain();
        send(32'h0, 3, -1);           drain();
        chk("first_syn_3", 64'(first_syn_o), 64'd3);
        chk("single_cnt_1", 64'(single_cnt_o), 64'd1);
        send(32'h0, 0, -1);           drain();
        send(32'h0, 1, 2);            drain();
        send(32'hA5A5_5A5A, 38, -1);  drain();
        send(32'h1234_5678, 0, 17);   drain();

        // Stream of 8 with consumer stalled for three cycles.
        chk_lat = 1'b0;
        n_deliv = 0; bp_cnt = 0; bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) send($urandom, (i % 3 == 0) ? int'($urandom_range(N)) : -1, -1);
        drain();
        bp_mode = 1'b0; out_ready_i = 1'b1;
        chk("stream_count", 64'(n_deliv), 64'd8);

        // Saturation on the narrow counter, then clear coinciding with a transfer.
        cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
        for (int i = 0; i < 5; i++) send($urandom, int'($urandom_range(N)), -1);
        drain();
        chk("sat_cnt_w2", 64'(sc2), 64'd3);
        cnt_clr_i = 1'b1;
        send($urandom, 5, -1);
        drain();
        cnt_clr_i = 1'b0;
        tick();
        chk("clr_cnt_w2", 64'(sc2), 64'd0);
        chk("clr_first_vld", 64'(fv2), 64'd0);

        // Reset with two words in flight.
        send($urandom, 7, -1); send($urandom, 9, 11); drain();
        send($urandom, 4, -1); send($urandom, -1, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_single_cnt", 64'(single_cnt_o), 64'd0);
        chk("midrst_double_cnt", 64'(double_cnt_o), 64'd0);
        chk("midrst_first_vld", 64'(first_syn_vld_o), 64'd0);
        q_exp.delete(); zero_model(); stalled = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Random traffic.
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d0 = $urandom_range(2);
            p1 = (d0 >= 1) ? int'($urandom_range(N)) : -1;
            p2 = -1;
            if (d0 == 2) begin
                p2 = int'($urandom_range(N));
                if (p2 == p1) p2 = (p1 + 1) % (N + 1);
            end
            send($urandom, p1, p2);
            if ($urandom_range(3) == 0) tick();
        end
        rnd_mode = 1'b0; out_ready_i = 1'b1; cnt_clr_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
